// File: rtl/rshift_ctrl_pkg.sv
// Shared types and helpers for the receive shift-chain sequencer.
package rshift_ctrl_pkg;

  // Sequencer states; encodings are fixed so other blocks can decode them.
  typedef enum logic [1:0] {
    RS_IDLE  = 2'd0,
    RS_CLEAR = 2'd1,
    RS_SHIFT = 2'd2,
    RS_HOLD  = 2'd3
  } rs_state_e;

  // A field length is usable only if it selects at least one cell and no
  // more cells than the chain has.
  function automatic logic len_in_range(input int len, input int max_len);
    return (len >= 1) && (len <= max_len);
  endfunction

endpackage

// File: rtl/rshift_ctrl.sv
// Receive shift-chain sequencer: turns bit-time sample pulses into one-cycle
// shift enables for an external chain of enable-gated cells, skips stuff
// bits, counts captured bits up to the programmed length and holds the word
// for a consumer with a valid/ack handshake.
module rshift_ctrl
  import rshift_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNTW  = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [CNTW-1:0] len,
  input  logic            sample,
  input  logic            stuff,
  input  logic            bit_in,
  input  logic            abort,
  input  logic            word_ack,
  output logic            shift_en,
  output logic            shift_in,
  output logic            cell_clr_n,
  output logic            busy,
  output logic            word_valid,
  output logic            overrun,
  output logic [CNTW-1:0] bit_cnt
);

  rs_state_e       state;
  logic [CNTW-1:0] len_q;
  logic            start_ok;
  logic            take;
  logic [CNTW-1:0] cnt_inc;
  logic            last_shift;

  assign start_ok   = start && len_in_range(int'(len), WIDTH);
  assign take       = sample && !stuff;
  assign cnt_inc    = bit_cnt + {{(CNTW-1){1'b0}}, 1'b1};
  // The shift happening this cycle completes the field, so the FSM is
  // already logically in HOLD: a data sample now is an overrun, not data.
  assign last_shift = shift_en && (cnt_inc == len_q);

  // Sequencer FSM with all outputs registered; abort outranks everything.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= RS_IDLE;
      len_q      <= {CNTW{1'b0}};
      bit_cnt    <= {CNTW{1'b0}};
      shift_en   <= 1'b0;
      shift_in   <= 1'b0;
      cell_clr_n <= 1'b1;
      busy       <= 1'b0;
      word_valid <= 1'b0;
      overrun    <= 1'b0;
    end else if (abort) begin
      // Any pending shift is dropped; the chain itself keeps its contents
      // and is cleared by the next start.
      state      <= RS_IDLE;
      bit_cnt    <= {CNTW{1'b0}};
      shift_en   <= 1'b0;
      shift_in   <= 1'b0;
      cell_clr_n <= 1'b1;
      busy       <= 1'b0;
      word_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      shift_en   <= 1'b0;
      shift_in   <= 1'b0;
      cell_clr_n <= 1'b1;
      case (state)
        RS_IDLE: begin
          if (start_ok) begin
            len_q      <= len;
            state      <= RS_CLEAR;
            cell_clr_n <= 1'b0;
            bit_cnt    <= {CNTW{1'b0}};
            overrun    <= 1'b0;
            busy       <= 1'b1;
          end
        end
        RS_CLEAR: begin
          state   <= RS_SHIFT;
          bit_cnt <= {CNTW{1'b0}};
          overrun <= 1'b0;
        end
        RS_SHIFT: begin
          if (shift_en) begin
            bit_cnt <= cnt_inc;
          end
          if (last_shift) begin
            state      <= RS_HOLD;
            word_valid <= 1'b1;
            if (take) begin
              overrun <= 1'b1;
            end
          end else if (take) begin
            shift_en <= 1'b1;
            shift_in <= bit_in;
          end
        end
        RS_HOLD: begin
          if (take) begin
            overrun <= 1'b1;
          end
          if (word_ack) begin
            word_valid <= 1'b0;
            if (start_ok) begin
              // Consumer releases the word and re-arms in one go.
              len_q      <= len;
              state      <= RS_CLEAR;
              cell_clr_n <= 1'b0;
              bit_cnt    <= {CNTW{1'b0}};
              overrun    <= 1'b0;
            end else begin
              state <= RS_IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state      <= RS_IDLE;
          busy       <= 1'b0;
          word_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rshift_ctrl.sv
// Self-checking bench for rshift_ctrl: directed scenarios plus randomized
// captures checked against an abstract model of accepted bits.
module tb_rshift_ctrl;

  logic       clock, reset, start, sample, stuff, bit_in, abort, word_ack;
  logic [3:0] len;
  logic       shift_en, shift_in, cell_clr_n, busy, word_valid, overrun;
  logic [3:0] bit_cnt;

  int checks   = 0;
  int failures = 0;

  // model state: accepted bits of the current capture
  int         m_len, m_acc, m_acc_prev;
  logic       m_last, m_ovr;
  logic [7:0] m_word;

  // external cell chain as the parent would build it
  logic [7:0] chain;
  int         pulses;

  rshift_ctrl #(.WIDTH(8), .CNTW(4)) dut (
    .clock(clock), .reset(reset), .start(start), .len(len),
    .sample(sample), .stuff(stuff), .bit_in(bit_in), .abort(abort),
    .word_ack(word_ack), .shift_en(shift_en), .shift_in(shift_in),
    .cell_clr_n(cell_clr_n), .busy(busy), .word_valid(word_valid),
    .overrun(overrun), .bit_cnt(bit_cnt)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // chain of enable-gated cells, first bit ends up in the MSB
  always @(posedge clock) begin
    if (!cell_clr_n) chain <= 8'h00;
    else if (shift_en) chain <= {chain[6:0], shift_in};
    if (shift_en) pulses <= pulses + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic begin_capture(input int l);
    start = 1'b1; len = 4'(l);
    tick();
    start = 1'b0;
    chk("clear_clr_n", 32'(cell_clr_n), 32'd0);
    chk("clear_busy", 32'(busy), 32'd1);
    chk("clear_cnt", 32'(bit_cnt), 32'd0);
    tick();
    m_len = l; m_acc = 0; m_acc_prev = 0; m_last = 1'b0; m_ovr = 1'b0; m_word = 8'h00;
  endtask

  // one cycle of bus activity, checked against the accepted-bit model
  task automatic step(input logic s, input logic st, input logic b);
    logic t;
    t = s && !st;
    sample = s; stuff = st; bit_in = b;
    tick();
    sample = 1'b0; stuff = 1'b0; bit_in = 1'b0;
    m_acc_prev = m_acc;
    if (t && m_acc < m_len) begin
      m_acc++;
      m_word = {m_word[6:0], b};
      m_last = 1'b1;
    end else begin
      m_last = 1'b0;
      if (t) m_ovr = 1'b1;
    end
    chk("shift_en", 32'(shift_en), 32'(m_last));
    if (m_last) chk("shift_in", 32'(shift_in), 32'(b));
    chk("bit_cnt", 32'(bit_cnt), 32'(m_acc_prev));
    chk("word_valid", 32'(word_valid), 32'(m_acc_prev == m_len));
    chk("overrun", 32'(overrun), 32'(m_ovr));
    chk("busy", 32'(busy), 32'd1);
  endtask

  task automatic finish_capture();
    chk("chain_word", 32'(chain), 32'(m_word));
    word_ack = 1'b1;
    tick();
    word_ack = 1'b0;
    chk("ack_valid", 32'(word_valid), 32'd0);
    chk("ack_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [7:0] pat;
    logic [5:0] stf;
    int         n;
    pulses = 0;
    reset = 1'b0; start = 1'b0; len = 4'd0; sample = 1'b0; stuff = 1'b0;
    bit_in = 1'b0; abort = 1'b0; word_ack = 1'b0;
    tick(); tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_clr_n", 32'(cell_clr_n), 32'd1);
    reset = 1'b1;
    tick();

    // 1: async reset in the middle of SHIFT with bit_cnt=3
    begin_capture(8);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'(i));
    step(1'b0, 1'b0, 1'b0);
    chk("t1_cnt3", 32'(bit_cnt), 32'd3);
    #2 reset = 1'b0;
    #1;
    chk("t1_rst_vec", {25'd0, shift_en, shift_in, cell_clr_n, busy, word_valid, overrun, 1'b0},
        {25'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    chk("t1_rst_cnt", 32'(bit_cnt), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    chk("t1_idle", 32'(busy), 32'd0);

    // 2: len=8, back-to-back bits 1,0,1,1,0,0,1,0
    pat = 8'b10110010;
    begin_capture(8);
    pulses = 0;
    for (int i = 7; i >= 0; i--) step(1'b1, 1'b0, pat[i]);
    step(1'b0, 1'b0, 1'b0);
    chk("t2_valid", 32'(word_valid), 32'd1);
    chk("t2_pulses", 32'(pulses), 32'd8);
    chk("t2_chain", 32'(chain), 32'hB2);
    finish_capture();

    // 3: len=4 with stuff pattern 0,1,0,0,1,0
    stf = 6'b010010;
    begin_capture(4);
    for (int i = 0; i < 6; i++) step(1'b1, stf[i], 1'($urandom_range(0, 1)));
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    finish_capture();

    // 4: overrun in HOLD, then ack together with a new start
    begin_capture(2);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    chk("t4_ovr", 32'(overrun), 32'd1);
    chk("t4_chain", 32'(chain), 32'h02);
    word_ack = 1'b1; start = 1'b1; len = 4'd3;
    tick();
    word_ack = 1'b0; start = 1'b0;
    chk("t4_clr_n", 32'(cell_clr_n), 32'd0);
    chk("t4_ovr0", 32'(overrun), 32'd0);
    chk("t4_busy", 32'(busy), 32'd1);
    chk("t4_valid", 32'(word_valid), 32'd0);
    tick();
    m_len = 3; m_acc = 0; m_acc_prev = 0; m_ovr = 1'b0; m_word = 8'h00;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'($urandom_range(0, 1)));
    finish_capture();

    // randomized captures
    for (int it = 0; it < 8; it++) begin
      begin_capture($urandom_range(1, 8));
      n = 0;
      while (!(m_acc_prev == m_len && n > 0) && n < 300) begin
        step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
        n++;
      end
      chk("rand_done", 32'(n < 300), 32'd1);
      for (int k = 0; k < 3; k++)
        step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
      finish_capture();
    end

    // 5a: abort with a sample in the same cycle at bit_cnt=5
    begin_capture(8);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    chk("t5_cnt5", 32'(bit_cnt), 32'd5);
    sample = 1'b1; abort = 1'b1;
    tick();
    sample = 1'b0; abort = 1'b0;
    chk("t5a_shift", 32'(shift_en), 32'd0);
    chk("t5a_busy", 32'(busy), 32'd0);
    chk("t5a_cnt", 32'(bit_cnt), 32'd0);
    chk("t5a_valid", 32'(word_valid), 32'd0);
    // 5b: abort in the cycle after a sample, bit_cnt=5
    begin_capture(8);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t5b_shift", 32'(shift_en), 32'd0);
    chk("t5b_cnt", 32'(bit_cnt), 32'd0);
    chk("t5b_busy", 32'(busy), 32'd0);
    tick();
    chk("t5b_idle_cnt", 32'(bit_cnt), 32'd0);

    // 6: illegal lengths are ignored, samples in IDLE do nothing
    start = 1'b1; len = 4'd0;
    tick();
    chk("t6_len0", 32'(busy), 32'd0);
    len = 4'd9;
    tick();
    start = 1'b0;
    chk("t6_len9", 32'(busy), 32'd0);
    sample = 1'b1;
    tick();
    sample = 1'b0;
    chk("t6_idle_shift", 32'(shift_en), 32'd0);
    tick();
    chk("t6_idle_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
